ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_ctrl.sv | 99 +++++++++
 tb/tb_ram_bist_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// Single-pass RAM BIST sequencer: writes an incrementing pattern from a seed,
// reads it back and counts mismatches against the same pattern.
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] seed_q;
  logic [DATA_W-1:0] addr_ext;
  logic [DATA_W-1:0] pattern;
  logic              chk_v;
  logic [DATA_W-1:0] chk_exp;
  logic              mismatch;

  assign addr_ext = DATA_W'(addr);
  assign pattern  = seed_q + addr_ext;

  // Read data returns one cycle after rd_en, so the expected value rides one stage behind.
  assign mismatch = chk_v && (rd_data != chk_exp);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      addr    <= '0;
      seed_q  <= '0;
      chk_v   <= 1'b0;
      chk_exp <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      chk_v   <= (state == READ);
      chk_exp <= pattern;
      if (mismatch) begin
        err <= 1'b1;
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            seed_q  <= seed;
            err     <= 1'b0;
            err_cnt <= '0;
            addr    <= '0;
            state   <= WRITE;
          end
        end
        WRITE: begin
          addr <= addr + ADDR_ONE;
          if (addr == ADDR_MAX) state <= READ;
        end
        READ: begin
          addr <= addr + ADDR_ONE;
          if (addr == ADDR_MAX) state <= DRAIN;
        end
        DRAIN:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so a reset clears them at once.
  assign wr_en   = (state == WRITE);
  assign wr_addr = addr;
  assign wr_data = pattern;
  assign rd_en   = (state == READ);
  assign rd_addr = addr;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with fault injection, expectation queues
// filled at each accepted start and drained by an independent output monitor.
module tb_ram_bist_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [DATA_W-1:0] seed_in = '0;
  logic              wr_en, rd_en, busy, done, err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic [ADDR_W:0]   err_cnt;

  ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .seed(seed_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  // RAM model: synchronous write, registered read, selected addresses read back inverted
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  corrupt = '0;
  initial begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= corrupt[rd_addr] ? ~mem[rd_addr] : mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int checks = 0;
  int passes = 0;
  logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
  logic [ADDR_W-1:0]        rd_exp_q[$];
  logic [31:0]              done_cyc_q[$];
  logic [ADDR_W+1:0]        done_res_q[$];
  logic [ADDR_W+1:0]        last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (wr_en || rd_en) begin
          check("no_overlap", 64'(wr_en & rd_en), 64'd0);
          check("busy_active", 64'(busy), 64'd1);
        end
        if (wr_en) begin
          if (wr_exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
          else check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(wr_exp_q.pop_front()));
        end
        if (rd_en) begin
          if (rd_exp_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
          else check("rd_addr", 64'(rd_addr), 64'(rd_exp_q.pop_front()));
        end
        if (done) begin
          if (done_cyc_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
          else begin
            check("done_cycle", 64'(cyc), 64'(done_cyc_q.pop_front()));
            check("done_err_cnt_err", 64'({err_cnt, err}), 64'(done_res_q.pop_front()));
            check("busy_done", 64'(busy), 64'd1);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic issue_start(input logic [DATA_W-1:0] s, input logic [DEPTH-1:0] mask,
                             input bit release_rst);
    int n;
    @(negedge clk);
    if (release_rst) n_rst = 1'b1;
    corrupt = mask;
    start   = 1'b1;
    seed_in = s;
    n = $countones(mask);
    for (int i = 0; i < DEPTH; i++) begin
      wr_exp_q.push_back({ADDR_W'(i), DATA_W'((int'(s) + i) % (1 << DATA_W))});
      rd_exp_q.push_back(ADDR_W'(i));
    end
    // The start edge ends cycle cyc; done occupies the (2*DEPTH+2)th cycle after it.
    done_cyc_q.push_back(32'(cyc + 1 + 2 * DEPTH + 1));
    last_res = {(ADDR_W+1)'(n), n != 0};
    done_res_q.push_back(last_res);
  endtask

  task automatic wait_done(input bit ignore);
    bit seen = 0;
    for (int k = 0; k < 4 * DEPTH && !seen; k++) begin
      @(negedge clk);
      start   = 1'b0;
      seed_in = DATA_W'($urandom);
      if (done) begin
        seen = 1;
        if (ignore) start = 1'b1;
      end else if (ignore && (k == 5 || k == DEPTH + 5)) begin
        start = 1'b1;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      check("result_hold", 64'({err_cnt, err}), 64'(last_res));
      check("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({wr_en, rd_en, busy, done, err, err_cnt, wr_addr, wr_data, rd_addr}), 64'd0);
  endtask

  initial begin
    bit found;
    // reset state, then a start on the first edge after release
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    issue_start(8'h10, '0, 1'b1);
    wait_done(1'b0);
    idle_check(3);

    // faults at addresses 5 and 12, result held through idle
    issue_start(8'h5A, 16'h1020, 1'b0);
    wait_done(1'b0);
    idle_check(10);

    // data wrap
    issue_start(8'hF8, '0, 1'b0);
    wait_done(1'b0);
    idle_check(2);

    // start pulses in WRITE, READ and DONE are ignored
    issue_start(8'h33, '0, 1'b0);
    wait_done(1'b1);
    idle_check(4);

    // every address corrupted, then a back-to-back start right after done
    issue_start(8'h77, '1, 1'b0);
    wait_done(1'b0);
    issue_start(8'h42, '0, 1'b0);
    wait_done(1'b0);
    idle_check(2);

    // reset at read address 7
    issue_start(8'hC3, '0, 1'b0);
    found = 0;
    for (int k = 0; k < 4 * DEPTH && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en && rd_addr == ADDR_W'(7)) found = 1;
    end
    check("reached_read7", 64'(found), 64'd1);
    #2 n_rst = 1'b0;
    #1 check_all_zero("abort_outputs");
    wr_exp_q.delete();
    rd_exp_q.delete();
    done_cyc_q.delete();
    done_res_q.delete();
    last_res = '0;
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    idle_check(2 * DEPTH + 4);
    issue_start(8'h10, '0, 1'b0);
    wait_done(1'b0);
    idle_check(2);

    // random seeds with sparse random faults
    for (int p = 0; p < 5; p++) begin
      issue_start(DATA_W'($urandom), DEPTH'($urandom & $urandom & $urandom), 1'b0);
      wait_done(1'b0);
      idle_check($urandom_range(0, 3));
    end

    idle_check(2);
    check("queues_drained",
          64'(wr_exp_q.size() + rd_exp_q.size() + done_cyc_q.size() + done_res_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
